// File: rtl/id_ex_stage.sv
// Operand fetch with RAW forwarding/stall resolution and a valid/ready ID/EX register.
// Define IDEX_FORWARD_EN to enable EX/MEM/WB forwarding; otherwise any pending write stalls.
module id_ex_stage #(
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_imm,
    input  logic [4:0]        in_rs1_addr,
    input  logic [4:0]        in_rs2_addr,
    input  logic [4:0]        in_rd_addr,
    input  logic              in_rs1_used,
    input  logic              in_rs2_used,
    input  logic              in_rd_wen,
    input  logic              in_is_load,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_rs1_addr,
    output logic [4:0]        rf_rs2_addr,
    input  logic [31:0]       rf_rs1_data,
    input  logic [31:0]       rf_rs2_data,
    input  logic [31:0]       ex_data,
    input  logic [4:0]        mem_rd_addr,
    input  logic              mem_wen,
    input  logic [31:0]       mem_data,
    input  logic [4:0]        wb_rd_addr,
    input  logic              wb_wen,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_imm,
    output logic [31:0]       out_rs1,
    output logic [31:0]       out_rs2,
    output logic [4:0]        out_rd_addr,
    output logic              out_rd_wen,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic              rd_wen_q, rd_wen_d, is_load_q, is_load_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic            hz, advance, capture;
    logic [XLEN-1:0] op1, op2;

    assign rf_rs1_addr = in_rs1_addr;
    assign rf_rs2_addr = in_rs2_addr;

`ifdef IDEX_FORWARD_EN
    logic ex_fwd_ok, ld_pending;

    // Only a non-load in EX has its result ready this cycle.
    assign ex_fwd_ok  = valid_q & rd_wen_q & ~is_load_q;
    assign ld_pending = valid_q & is_load_q & rd_wen_q & (rd_q != 5'd0);
    assign hz = ld_pending & ((in_rs1_used & (rd_q == in_rs1_addr)) |
                              (in_rs2_used & (rd_q == in_rs2_addr)));

    always_comb begin
        op1 = rf_rs1_data;
        op2 = rf_rs2_data;
        if (in_rs1_used) begin
            if (ex_fwd_ok && rd_q == in_rs1_addr)          op1 = ex_data;
            else if (mem_wen && mem_rd_addr == in_rs1_addr) op1 = mem_data;
            else if (wb_wen && wb_rd_addr == in_rs1_addr)   op1 = wb_data;
        end
        if (in_rs2_used) begin
            if (ex_fwd_ok && rd_q == in_rs2_addr)          op2 = ex_data;
            else if (mem_wen && mem_rd_addr == in_rs2_addr) op2 = mem_data;
            else if (wb_wen && wb_rd_addr == in_rs2_addr)   op2 = wb_data;
        end
        if (in_rs1_addr == 5'd0) op1 = '0;
        if (in_rs2_addr == 5'd0) op2 = '0;
    end
`else
    logic src1_busy, src2_busy;
    logic unused_fwd_data;

    // Without forwarding, any in-flight write to a used source must drain first.
    assign src1_busy = in_rs1_used & (in_rs1_addr != 5'd0) &
                       ((valid_q & rd_wen_q & (rd_q == in_rs1_addr)) |
                        (mem_wen & (mem_rd_addr == in_rs1_addr)) |
                        (wb_wen & (wb_rd_addr == in_rs1_addr)));
    assign src2_busy = in_rs2_used & (in_rs2_addr != 5'd0) &
                       ((valid_q & rd_wen_q & (rd_q == in_rs2_addr)) |
                        (mem_wen & (mem_rd_addr == in_rs2_addr)) |
                        (wb_wen & (wb_rd_addr == in_rs2_addr)));
    assign hz  = src1_busy | src2_busy;
    assign op1 = (in_rs1_addr == 5'd0) ? '0 : rf_rs1_data;
    assign op2 = (in_rs2_addr == 5'd0) ? '0 : rf_rs2_data;
    assign unused_fwd_data = ^{ex_data, mem_data, wb_data};
`endif

    assign advance  = ~valid_q | out_ready;
    assign in_ready = advance & ~hz & ~flush;
    assign capture  = in_valid & in_ready;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        is_load_d = is_load_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        if (in_valid && hz && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            pc_d      = in_pc;
            imm_d     = in_imm;
            rs1_d     = op1;
            rs2_d     = op2;
            rd_d      = in_rd_addr;
            rd_wen_d  = in_rd_wen;
            is_load_d = in_is_load;
            ctrl_d    = in_ctrl;
        end else if (advance) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            is_load_q <= 1'b0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rd_wen_q  <= rd_wen_d;
            is_load_q <= is_load_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_imm     = imm_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd_addr = rd_q;
    assign out_rd_wen  = rd_wen_q;
    assign out_is_load = is_load_q;
    assign out_ctrl    = ctrl_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model of the stage.
module tb_id_ex_stage;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic        in_rs1_used, in_rs2_used, in_rd_wen, in_is_load;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data, ex_data;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_wen, wb_wen;
    logic [31:0] mem_data, wb_data;
    logic        flush, out_valid, out_ready;
    logic [31:0] out_pc, out_imm, out_rs1, out_rs2;
    logic [4:0]  out_rd_addr;
    logic        out_rd_wen, out_is_load;
    logic [15:0] out_ctrl, stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the out register and stall counter
    logic        m_valid, m_rd_wen, m_is_load;
    logic [31:0] m_pc, m_imm, m_rs1, m_rs2;
    logic [4:0]  m_rd;
    logic [15:0] m_ctrl;
    int          m_cnt;

    id_ex_stage #(.CTRL_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .in_rd_wen(in_rd_wen), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_data(ex_data),
        .mem_rd_addr(mem_rd_addr), .mem_wen(mem_wen), .mem_data(mem_data),
        .wb_rd_addr(wb_rd_addr), .wb_wen(wb_wen), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd_addr(out_rd_addr), .out_rd_wen(out_rd_wen), .out_is_load(out_is_load),
        .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IDEX_FORWARD_EN
    function automatic logic model_hz();
        return m_valid && m_is_load && m_rd_wen && m_rd != 5'd0 &&
               ((in_rs1_used && m_rd == in_rs1_addr) || (in_rs2_used && m_rd == in_rs2_addr));
    endfunction

    function automatic logic [31:0] model_operand(input logic [4:0] a, input logic used,
                                                  input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (used) begin
            if (m_valid && m_rd_wen && !m_is_load && m_rd == a) return ex_data;
            if (mem_wen && mem_rd_addr == a) return mem_data;
            if (wb_wen && wb_rd_addr == a) return wb_data;
        end
        return rf;
    endfunction
`else
    function automatic logic src_pending(input logic [4:0] a, input logic used);
        return used && a != 5'd0 &&
               ((m_valid && m_rd_wen && m_rd == a) || (mem_wen && mem_rd_addr == a) ||
                (wb_wen && wb_rd_addr == a));
    endfunction

    function automatic logic model_hz();
        return src_pending(in_rs1_addr, in_rs1_used) || src_pending(in_rs2_addr, in_rs2_used);
    endfunction

    function automatic logic [31:0] model_operand(input logic [4:0] a, input logic used,
                                                  input logic [31:0] rf);
        if (a == 5'd0 || !used) return (a == 5'd0) ? 32'd0 : rf;
        return rf;
    endfunction
`endif

    function automatic logic model_in_ready();
        return (!m_valid || out_ready) && !model_hz() && !flush;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rd_wen = 0; m_is_load = 0;
        m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0; m_cnt = 0;
    endtask

    // Advance model by one edge using current inputs, then clock the DUT.
    task automatic tick();
        logic adv, acc, hzv;
        logic [31:0] o1, o2;
        adv = !m_valid || out_ready;
        hzv = model_hz();
        acc = in_valid && model_in_ready();
        o1  = model_operand(in_rs1_addr, in_rs1_used, rf_rs1_data);
        o2  = model_operand(in_rs2_addr, in_rs2_used, rf_rs2_data);
        if (in_valid && hzv && m_cnt < 65535) m_cnt++;
        if (flush) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_rs1 = o1; m_rs2 = o2;
            m_rd = in_rd_addr; m_rd_wen = in_rd_wen; m_is_load = in_is_load; m_ctrl = in_ctrl;
        end else if (adv) m_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; in_pc = 0; in_imm = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
        in_rs1_used = 0; in_rs2_used = 0; in_rd_wen = 0; in_is_load = 0; in_ctrl = 0;
        rf_rs1_data = 0; rf_rs2_data = 0; ex_data = $urandom;
        mem_rd_addr = 0; mem_wen = 0; mem_data = $urandom;
        wb_rd_addr = 0; wb_wen = 0; wb_data = $urandom;
        flush = 0; out_ready = 1;
    endtask

    task automatic load_instr(input logic [4:0] rd, input logic is_ld, input logic [4:0] rs1,
                              input logic u1, input logic [4:0] rs2, input logic u2);
        in_valid = 1; in_pc = $urandom; in_imm = $urandom; in_ctrl = 16'($urandom);
        in_rd_addr = rd; in_rd_wen = 1; in_is_load = is_ld;
        in_rs1_addr = rs1; in_rs1_used = u1; in_rs2_addr = rs2; in_rs2_used = u2;
    endtask

    task automatic test_reset();
        rst = 0;
        in_valid = 1; in_pc = $urandom; in_imm = $urandom; in_rs1_addr = 5'($urandom);
        in_rs2_addr = 5'($urandom); in_rd_addr = 5'($urandom); in_rs1_used = 1; in_rs2_used = 1;
        in_rd_wen = 1; in_is_load = 1; in_ctrl = 16'($urandom);
        rf_rs1_data = $urandom; rf_rs2_data = $urandom; ex_data = $urandom;
        mem_rd_addr = 5'($urandom); mem_wen = 1; mem_data = $urandom;
        wb_rd_addr = 5'($urandom); wb_wen = 1; wb_data = $urandom; flush = 0; out_ready = 1;
        model_reset();
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (out_rs1 !== 32'd0) begin n_errors++; $display("FAIL reset_rs1: got %h want 0", out_rs1); end
        n_checks++; if (out_pc !== 32'd0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        @(posedge clk); #1;
        rst = 1;
        set_idle();
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_ex_forward();
        set_idle();
        load_instr(5'd5, 0, 5'd1, 1, 5'd0, 0);
        rf_rs1_data = 32'h0000_0001;
        #1; tick();
        n_checks++; if (out_valid !== 1'b1 || out_rd_addr !== 5'd5) begin n_errors++;
            $display("FAIL exfwd_capture: got v=%b rd=%0d want v=1 rd=5", out_valid, out_rd_addr); end
        load_instr(5'd6, 0, 5'd5, 1, 5'd0, 0);
        rf_rs1_data = 32'd0; ex_data = 32'h0000_0010;
        #1;
        n_checks++; if (in_ready !== model_in_ready()) begin n_errors++;
            $display("FAIL exfwd_in_ready: got %b want %b", in_ready, model_in_ready()); end
`ifdef IDEX_FORWARD_EN
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL exfwd_nostall: got %b want 1", in_ready); end
`endif
        tick();
        n_checks++; if (out_valid !== m_valid) begin n_errors++;
            $display("FAIL exfwd_valid: got %b want %b", out_valid, m_valid); end
`ifdef IDEX_FORWARD_EN
        n_checks++; if (out_rs1 !== 32'h10) begin n_errors++; $display("FAIL exfwd_rs1: got %h want 00000010", out_rs1); end
`endif
        set_idle(); tick();
    endtask

    task automatic test_load_use();
        int c0;
        set_idle();
        load_instr(5'd7, 1, 5'd0, 0, 5'd0, 0);
        #1; tick();
        load_instr(5'd8, 0, 5'd0, 1, 5'd7, 1);
        rf_rs2_data = 32'h1111_1111;
        #1;
        c0 = int'(stall_cnt);
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL lu_in_ready: got %b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL lu_bubble: got %b want 0", out_valid); end
        n_checks++; if (int'(stall_cnt) != c0 + 1) begin n_errors++;
            $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, c0 + 1); end
        mem_wen = 1; mem_rd_addr = 5'd7; mem_data = 32'hDEAD_BEEF;
        #1; tick();
        n_checks++; if (out_valid !== m_valid || stall_cnt !== 16'(m_cnt)) begin n_errors++;
            $display("FAIL lu_mem: got v=%b cnt=%0d want v=%b cnt=%0d", out_valid, stall_cnt, m_valid, m_cnt); end
`ifdef IDEX_FORWARD_EN
        n_checks++; if (out_rs2 !== 32'hDEAD_BEEF) begin n_errors++;
            $display("FAIL lu_rs2: got %h want deadbeef", out_rs2); end
`endif
        set_idle(); tick(); tick();
    endtask

    task automatic test_x0_unused();
        set_idle();
        load_instr(5'd0, 1, 5'd0, 0, 5'd0, 0);
        #1; tick();
        load_instr(5'd9, 1, 5'd0, 1, 5'd0, 0);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL x0_nostall: got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_rs1 !== 32'd0) begin n_errors++;
            $display("FAIL x0_rs1: got v=%b rs1=%h want v=1 rs1=0", out_valid, out_rs1); end
        load_instr(5'd10, 0, 5'd0, 1, 5'd9, 0);
        rf_rs2_data = 32'h2222_2222;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL unused_nostall: got %b want 1", in_ready); end
        tick();
        set_idle(); tick();
    endtask

    task automatic test_backpressure_flush();
        logic [31:0] pc0, rs10;
        set_idle();
        load_instr(5'd11, 0, 5'd2, 1, 5'd3, 1);
        rf_rs1_data = $urandom; rf_rs2_data = $urandom;
        #1; tick();
        pc0 = m_pc; rs10 = m_rs1;
        for (int i = 0; i < 3; i++) begin
            load_instr(5'd12, 0, 5'd4, 0, 5'd4, 0);
            out_ready = 0;
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_pc !== pc0 || out_rs1 !== rs10) begin n_errors++;
                $display("FAIL bp_hold%0d: got v=%b pc=%h rs1=%h want v=1 pc=%h rs1=%h", i, out_valid, out_pc, out_rs1, pc0, rs10); end
        end
        flush = 1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        set_idle(); tick();
    endtask

    task automatic test_wb_stall();
        int c0;
        set_idle();
        c0 = m_cnt;
        load_instr(5'd13, 0, 5'd3, 1, 5'd0, 0);
        wb_wen = 1; wb_rd_addr = 5'd3; wb_data = 32'hCAFE_0003; rf_rs1_data = 32'h0BAD_0BAD;
        #1;
        n_checks++; if (in_ready !== model_in_ready()) begin n_errors++;
            $display("FAIL wb_in_ready: got %b want %b", in_ready, model_in_ready()); end
        tick();
        wb_wen = 0; rf_rs1_data = 32'hCAFE_0003;
        #1; tick();
        n_checks++; if (out_valid !== 1'b1 || out_rs1 !== 32'hCAFE_0003) begin n_errors++;
            $display("FAIL wb_rs1: got v=%b rs1=%h want v=1 rs1=cafe0003", out_valid, out_rs1); end
`ifdef IDEX_FORWARD_EN
        n_checks++; if (int'(stall_cnt) != c0) begin n_errors++; $display("FAIL wb_cnt: got %0d want %0d", stall_cnt, c0); end
`else
        n_checks++; if (int'(stall_cnt) != c0 + 1) begin n_errors++; $display("FAIL wb_cnt: got %0d want %0d", stall_cnt, c0 + 1); end
`endif
        set_idle(); tick();
    endtask

    task automatic test_reset_mid_stall();
        set_idle();
        load_instr(5'd7, 1, 5'd0, 0, 5'd0, 0);
        #1; tick();
        load_instr(5'd14, 0, 5'd7, 1, 5'd0, 0);
        rf_rs1_data = 32'h7777_7777;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rms_stall: got %b want 0", in_ready); end
        #2 rst = 0;
        model_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin n_errors++;
            $display("FAIL rms_clear: got v=%b cnt=%0d want v=0 cnt=0", out_valid, stall_cnt); end
        #1 rst = 1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_rs1 !== 32'h7777_7777) begin n_errors++;
            $display("FAIL rms_capture: got v=%b rs1=%h want v=1 rs1=77777777", out_valid, out_rs1); end
        set_idle(); tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc = $urandom; in_imm = $urandom; in_ctrl = 16'($urandom);
            in_rs1_addr = 5'($urandom_range(0, 7)); in_rs2_addr = 5'($urandom_range(0, 7));
            in_rd_addr = 5'($urandom_range(0, 7));
            in_rs1_used = 1'($urandom); in_rs2_used = 1'($urandom);
            in_rd_wen = 1'($urandom); in_is_load = ($urandom_range(0, 3) == 0);
            rf_rs1_data = (in_rs1_addr == 5'd0) ? 32'd0 : $urandom;
            rf_rs2_data = (in_rs2_addr == 5'd0) ? 32'd0 : $urandom;
            ex_data = $urandom;
            mem_wen = 1'($urandom); mem_rd_addr = 5'($urandom_range(0, 7)); mem_data = $urandom;
            wb_wen = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++; if (in_ready !== model_in_ready()) begin n_errors++;
                $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, in_ready, model_in_ready()); end
            n_checks++; if (rf_rs1_addr !== in_rs1_addr || rf_rs2_addr !== in_rs2_addr) begin n_errors++;
                $display("FAIL rnd_rf_addr[%0d]: got %0d/%0d want %0d/%0d", n, rf_rs1_addr, rf_rs2_addr, in_rs1_addr, in_rs2_addr); end
            tick();
            n_checks++; if (out_valid !== m_valid || stall_cnt !== 16'(m_cnt)) begin n_errors++;
                $display("FAIL rnd_state[%0d]: got v=%b cnt=%0d want v=%b cnt=%0d", n, out_valid, stall_cnt, m_valid, m_cnt); end
            if (m_valid) begin
                n_checks++; if (out_pc !== m_pc || out_imm !== m_imm) begin n_errors++;
                    $display("FAIL rnd_pcimm[%0d]: got %h/%h want %h/%h", n, out_pc, out_imm, m_pc, m_imm); end
                n_checks++; if (out_rs1 !== m_rs1 || out_rs2 !== m_rs2) begin n_errors++;
                    $display("FAIL rnd_ops[%0d]: got %h/%h want %h/%h", n, out_rs1, out_rs2, m_rs1, m_rs2); end
                n_checks++; if ({out_rd_wen, out_is_load, out_rd_addr, out_ctrl} !== {m_rd_wen, m_is_load, m_rd, m_ctrl}) begin
                    n_errors++;
                    $display("FAIL rnd_ctl[%0d]: got %b%b %0d %h want %b%b %0d %h", n, out_rd_wen, out_is_load,
                             out_rd_addr, out_ctrl, m_rd_wen, m_is_load, m_rd, m_ctrl); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_load_use();
        test_x0_unused();
        test_backpressure_flush();
        test_wb_stall();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Operand-fetch and ID/EX pipeline register for the RV32I core. Sits between decode and execute. It drives the register-file read addresses and resolves RAW hazards by forwarding from EX, MEM and WB, or by stalling on load-use. It then captures operands and control into a valid/ready-handshaked register that feeds the ALU.

## Interface

Parameters:
- CTRL_W, 16: width of opaque decoded control bundle passed to EX.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous, active-low.
- in_valid / in_ready, input / output, 1 / 1: decode-side handshake.
- in_pc, in_imm, input, 32 each: instruction PC and sign-extended immediate.
- in_rs1_addr, in_rs2_addr, in_rd_addr, input, 5 each: register specifiers.
- in_rs1_used, in_rs2_used, in_rd_wen, in_is_load, input, 1 each: source-use, write-enable and load flags.
- in_ctrl, input, CTRL_W: control bundle.
- rf_rs1_addr, rf_rs2_addr, output, 5 each: combinational copies of in_rs1_addr/in_rs2_addr.
- rf_rs1_data, rf_rs2_data, input, 32 each: register-file read data, combinational; x0 reads as 0.
- ex_data, input, 32: combinational EX result of the instruction currently held in the out register.
- mem_rd_addr, mem_wen, mem_data, input, 5/1/32: MEM-stage destination, write enable and result (load data included).
- wb_rd_addr, wb_wen, wb_data, input, 5/1/32: WB-stage write port, written to the register file at the next edge.
- flush, input, 1: synchronous kill from branch/jump resolution.
- out_valid / out_ready, output / input, 1 / 1: EX-side handshake.
- out_pc, out_imm, out_rs1, out_rs2, output, 32 each: registered PC, immediate and operands.
- out_rd_addr, out_rd_wen, out_is_load, out_ctrl, output, 5/1/1/CTRL_W: registered destination, flags and control.
- stall_cnt, output, 16: saturating count of load-use stall cycles.

## Operation

- Per-source forward select (source s with address a, a≠0, used): first match wins.
  - EX: out_valid & out_rd_wen & out_rd_addr==a & !out_is_load → ex_data.
  - MEM: mem_wen & mem_rd_addr==a → mem_data.
  - WB: wb_wen & wb_rd_addr==a → wb_data.
  - Otherwise rf data.
- a==0 always yields 0 and is never forwarded or stalled on.
- Load-use hazard (hz) = out_valid & out_is_load & out_rd_wen & out_rd_addr≠0 & ((in_rs1_used & out_rd_addr==in_rs1_addr) | (in_rs2_used & out_rd_addr==in_rs2_addr)).
- advance = !out_valid | out_ready.
- in_ready = advance & !hz & !flush.
- Register update priority:
  1. flush: out_valid←0.
  2. advance & in_valid & in_ready: capture all in_* and the forwarded operands; out_valid←1.
  3. advance & (hz or !in_valid): out_valid←0 (bubble).
  4. Otherwise hold all outputs unchanged.
- Out-register data fields update only on capture; they are don't-care when out_valid=0.
- stall_cnt increments on each cycle with in_valid & hz, saturating at 0xFFFF. It is not cleared by flush.

## Timing

- Reset (rst=0, async): out_valid=0, all out_* data=0, stall_cnt=0. in_ready becomes 1 once rst=1 and flush=0.
- Latency: 1 cycle from accepted input to out_valid=1.
- Throughput: 1 instruction/cycle with no hazards.
- Load-use costs exactly 1 bubble cycle. On the following cycle the load is in MEM and mem_data forwards.
- Holding: out_valid=1 & out_ready=0 keeps all out_* stable and in_ready=0. The EX forward path still applies to the held instruction.
- Flush at the same cycle as a hazard or a valid input: flush wins; the input is not accepted.
- Reset asserted mid-stall: state clears immediately, with no pending bubble retained.

## Configuration

- IDEX_FORWARD_EN defined: forwarding exactly as above.
- Undefined: all operands come from the rf inputs. hz widens to any used nonzero source matching a pending write in out (valid & rd_wen), MEM (mem_wen) or WB (wb_wen). Each such cycle is a stall, bubbles as above, and counts in stall_cnt.

## Test plan

- Reset: rst=0 with random inputs → out_valid=0, out_rs1=0, stall_cnt=0. After release, in_ready=1.
- EX forward (FORWARD_EN): addi x5 captured; next instr add rs1=x5 with ex_data=0x0000_0010 and rf_rs1_data=0 → out_rs1=0x10, no stall.
- Load-use: lw x7 in out, next uses rs2=x7 → in_ready=0 for 1 cycle, bubble, stall_cnt=1. Next cycle mem_data=0xDEADBEEF → out_rs2=0xDEADBEEF.
- x0 / unused source: out holds lw x0 and next reads x0 → no stall, out_rs1=0. rs2 matching a load rd with in_rs2_used=0 → no stall.
- Backpressure + flush: out_ready=0 for 3 cycles → out_* stable and in_ready=0. Assert flush → out_valid=0 next cycle, input not accepted.
- FORWARD_EN off: WB writes x3 while decode reads x3 → 1 stall cycle. Then rf_rs1_data value captured.
